// File: rtl/dafx_pkg.sv
// Shared types and default widths for the DAFX stereo gain stage.
package dafx_pkg;

    localparam int unsigned DATA_WIDTH_C  = 24;
    localparam int unsigned GAIN_WIDTH_C  = 16;
    localparam int unsigned GAIN_Q_BITS_C = 12;
    localparam int unsigned ERR_WIDTH_C   = 16;
    localparam int unsigned GAIN_UNITY_C  = 1 << GAIN_Q_BITS_C;

    typedef enum logic [1:0] {
        ST_PASS      = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_MUTED     = 2'd2,
        ST_RAMP_UP   = 2'd3
    } gain_mute_state_t;

endpackage

// File: rtl/dafx_sat_mult.sv
// Signed x unsigned multiply, arithmetic shift right (floor), saturate to O_W bits.
module dafx_sat_mult #(
    parameter int unsigned A_W   = 24,
    parameter int unsigned B_W   = 16,
    parameter int unsigned SHIFT = 12,
    parameter int unsigned O_W   = 24
) (
    input  logic signed [A_W-1:0] a,
    input  logic        [B_W-1:0] b,
    output logic signed [O_W-1:0] y
);

    localparam int unsigned P_W = A_W + B_W + 1;

    logic signed [P_W-1:0] prod_c;
    logic signed [P_W-1:0] shr_c;
    logic                  ovf_pos_c;
    logic                  ovf_neg_c;

    assign prod_c    = P_W'(a) * P_W'($signed({1'b0, b}));
    assign shr_c     = prod_c >>> SHIFT;
    assign ovf_pos_c = ~shr_c[P_W-1] & (|shr_c[P_W-2:O_W-1]);
    assign ovf_neg_c =  shr_c[P_W-1] & ~(&shr_c[P_W-2:O_W-1]);

    // Clamp to the output range when the shifted product does not fit
    always_comb begin
        y = shr_c[O_W-1:0];
        if (ovf_pos_c) begin
            y = {1'b0, {(O_W-1){1'b1}}};
        end else if (ovf_neg_c) begin
            y = {1'b1, {(O_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/dafx_stereo_gain.sv
// Stereo gain / soft-mute stage on the interleaved L,R ADC stream.
// Optional peak meter: define DAFX_STEREO_PEAK_METER_EN.
module dafx_stereo_gain
    import dafx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P  = DATA_WIDTH_C,
    parameter int unsigned GAIN_WIDTH_P  = GAIN_WIDTH_C,
    parameter int unsigned GAIN_Q_BITS_P = GAIN_Q_BITS_C,
    parameter int unsigned ERR_WIDTH_P   = ERR_WIDTH_C
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH_P-1:0]  ing_data,
    input  logic                     ing_valid,
    output logic                     ing_ready,
    input  logic                     ing_last,
    output logic [DATA_WIDTH_P-1:0]  egr_data,
    output logic                     egr_valid,
    input  logic                     egr_ready,
    output logic                     egr_last,
    input  logic [GAIN_WIDTH_P-1:0]  cfg_gain_l,
    input  logic [GAIN_WIDTH_P-1:0]  cfg_gain_r,
    input  logic                     cfg_mute,
    input  logic [GAIN_Q_BITS_P:0]   cfg_ramp_step,
    output logic [1:0]               sr_mute_state,
    output logic [ERR_WIDTH_P-1:0]   sr_frame_err,
    output logic [DATA_WIDTH_P-2:0]  sr_peak_l,
    output logic [DATA_WIDTH_P-2:0]  sr_peak_r,
    input  logic                     cfg_peak_clr
);

    localparam int unsigned ATT_W = GAIN_Q_BITS_P + 1;
    localparam int unsigned P1_W  = DATA_WIDTH_P + GAIN_WIDTH_P - GAIN_Q_BITS_P;
    localparam logic [ATT_W-1:0] ATT_UNITY = (GAIN_Q_BITS_P == GAIN_Q_BITS_C) ?
                                             ATT_W'(GAIN_UNITY_C) : (ATT_W'(1) << GAIN_Q_BITS_P);
    localparam logic [ERR_WIDTH_P-1:0] ERR_MAX = '1;

    logic                    run;
    logic                    advance_c;
    logic                    accept_c;
    logic                    frame_end_c;
    logic                    exp_r;
    logic [GAIN_WIDTH_P-1:0] gain_c;
    logic signed [P1_W-1:0]  p_c;
    logic signed [DATA_WIDTH_P-1:0] q_c;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [P1_W-1:0]  s1_data;
    logic [ATT_W-1:0]        s1_att;

    gain_mute_state_t        state_q;
    gain_mute_state_t        state_d;
    logic [ATT_W-1:0]        att_q;
    logic [ATT_W-1:0]        att_d;
    logic [ATT_W:0]          att_sum_c;

    assign advance_c   = egr_ready | ~egr_valid;
    assign ing_ready   = run & advance_c;
    assign accept_c    = ing_valid & ing_ready;
    assign frame_end_c = accept_c & ing_last;
    // Channel follows the beat's own last bit, so a misframed beat still gets its indicated gain
    assign gain_c      = ing_last ? cfg_gain_r : cfg_gain_l;
    assign att_sum_c   = {1'b0, att_q} + {1'b0, cfg_ramp_step};

    dafx_sat_mult #(
        .A_W  (DATA_WIDTH_P),
        .B_W  (GAIN_WIDTH_P),
        .SHIFT(GAIN_Q_BITS_P),
        .O_W  (P1_W)
    ) u_mult_gain (
        .a(ing_data),
        .b(gain_c),
        .y(p_c)
    );

    dafx_sat_mult #(
        .A_W  (P1_W),
        .B_W  (ATT_W),
        .SHIFT(GAIN_Q_BITS_P),
        .O_W  (DATA_WIDTH_P)
    ) u_mult_att (
        .a(s1_data),
        .b(s1_att),
        .y(q_c)
    );

    // Hold ingress off until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Framing tracker and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r        <= 1'b0;
            sr_frame_err <= '0;
        end else if (accept_c) begin
            exp_r <= ~ing_last;
            if ((ing_last != exp_r) && (sr_frame_err != ERR_MAX)) begin
                sr_frame_err <= sr_frame_err + ERR_WIDTH_P'(1);
            end
        end
    end

    // Two-stage pipeline; att travels with the beat so both channels of a frame share it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
            s1_att    <= '0;
            egr_valid <= 1'b0;
            egr_data  <= '0;
            egr_last  <= 1'b0;
        end else if (advance_c) begin
            s1_valid  <= accept_c;
            if (accept_c) begin
                s1_data <= p_c;
                s1_last <= ing_last;
                s1_att  <= att_q;
            end
            egr_valid <= s1_valid;
            if (s1_valid) begin
                egr_data <= q_c;
                egr_last <= s1_last;
            end
        end
    end

    // Mute ramp state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PASS;
            att_q   <= ATT_UNITY;
        end else begin
            state_q <= state_d;
            att_q   <= att_d;
        end
    end

    // Mute ramp next state: one step toward the cfg_mute target per frame boundary
    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        if (frame_end_c) begin
            if (cfg_mute) begin
                if ((cfg_ramp_step == '0) || (att_q <= cfg_ramp_step)) begin
                    att_d   = '0;
                    state_d = ST_MUTED;
                end else begin
                    att_d   = att_q - cfg_ramp_step;
                    state_d = ST_RAMP_DOWN;
                end
            end else begin
                if ((cfg_ramp_step == '0) || (att_sum_c >= {1'b0, ATT_UNITY})) begin
                    att_d   = ATT_UNITY;
                    state_d = ST_PASS;
                end else begin
                    att_d   = att_sum_c[ATT_W-1:0];
                    state_d = ST_RAMP_UP;
                end
            end
        end
    end

    assign sr_mute_state = state_q;

`ifdef DAFX_STEREO_PEAK_METER_EN
    logic [DATA_WIDTH_P-1:0] neg_c;
    logic [DATA_WIDTH_P-2:0] mag_c;
    logic [DATA_WIDTH_P-2:0] peak_l_q;
    logic [DATA_WIDTH_P-2:0] peak_r_q;

    assign neg_c = ~egr_data + DATA_WIDTH_P'(1);
    assign mag_c = !egr_data[DATA_WIDTH_P-1] ? egr_data[DATA_WIDTH_P-2:0] :
                   (neg_c[DATA_WIDTH_P-1] ? '1 : neg_c[DATA_WIDTH_P-2:0]);

    // Per-channel absolute peak hold; clear wins over a same-cycle beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (cfg_peak_clr) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (egr_valid && egr_ready) begin
            if (egr_last) begin
                if (mag_c > peak_r_q) peak_r_q <= mag_c;
            end else begin
                if (mag_c > peak_l_q) peak_l_q <= mag_c;
            end
        end
    end

    assign sr_peak_l = peak_l_q;
    assign sr_peak_r = peak_r_q;
`else
    logic peak_clr_unused;

    assign peak_clr_unused = cfg_peak_clr;
    assign sr_peak_l       = '0;
    assign sr_peak_r       = '0;
`endif

endmodule
